// File: rtl/warp_lsu_pkg.sv
// -----------------------------------------------------------------------------
// warp_lsu_pkg
// Shared types for the per-warp load/store unit:
//   data_t       - 32-bit machine word (addresses, store data, load results)
//   warp_state_t - warp pipeline phase as seen by the LSU
//   lsu_state_t  - LSU sequencer states
// -----------------------------------------------------------------------------
package warp_lsu_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/warp_lsu_if.sv
// -----------------------------------------------------------------------------
// warp_lsu_if
// Data-memory port between one warp LSU and the data-memory arbiter.
//   mem_req_valid/ready  - request handshake (LSU -> memory)
//   mem_req_we           - 1 = store, 0 = load
//   mem_req_addr/wdata   - byte address and store data
//   mem_rsp_valid/data   - load data or write ack (memory -> LSU), no ready
// Modports: master = LSU side, slave = memory side.
// -----------------------------------------------------------------------------
interface warp_lsu_if;
  import warp_lsu_pkg::*;

  logic  mem_req_valid;
  logic  mem_req_ready;
  logic  mem_req_we;
  data_t mem_req_addr;
  data_t mem_req_wdata;
  logic  mem_rsp_valid;
  data_t mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/warp_lsu_next_thread.sv
// -----------------------------------------------------------------------------
// lsu_next_thread
// Combinational find-first-set over a thread mask.
//   i_mask      - thread mask to search
//   i_idx       - current thread index; search starts strictly above it
//   i_from_zero - search from bit 0 inclusive (first pick of an operation)
//   o_found     - a qualifying set bit exists
//   o_next_idx  - lowest qualifying set bit (0 when none)
// -----------------------------------------------------------------------------
module lsu_next_thread #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_from_zero,
  output logic             o_found,
  output logic [IDX_W-1:0] o_next_idx
);

  // Scan from the top down so the lowest qualifying lane is the last
  // assignment and therefore wins.
  always_comb begin
    o_found    = 1'b0;
    o_next_idx = '0;
    for (int t = N - 1; t >= 0; t--) begin
      if (i_mask[t] && (i_from_zero || (t > int'(i_idx)))) begin
        o_found    = 1'b1;
        o_next_idx = IDX_W'(t);
      end
    end
  end

endmodule

// File: rtl/warp_lsu.sv
// -----------------------------------------------------------------------------
// warp_lsu
// Per-warp load/store unit. Captures per-thread operands when the warp
// enters WARP_WAIT with a memory instruction, then issues one memory access
// per enabled thread (lowest lane first) over a single valid/ready port,
// one request outstanding at a time. Load data lands in lsu_out for the
// register-file write-back in WARP_UPDATE.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   warp_state     - current warp phase
//   warp_enable    - warp selected this cycle (gates start only)
//   thread_enable  - execution mask
//   DMemEN         - instruction is a memory access
//   MemWrite       - 1 = store, 0 = load
//   imm            - sign-extended address offset
//   rs1, rs2       - per-thread base address / store data
//   lsu_out        - per-thread load results
//   lsu_done       - all enabled accesses complete
//   mem            - data-memory port (master side)
// -----------------------------------------------------------------------------
module warp_lsu
  import warp_lsu_pkg::*;
#(
  parameter int THREADS_PER_WARP = 4,
  parameter int IDX_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  warp_state_t                  warp_state,
  input  logic                         warp_enable,
  input  logic [THREADS_PER_WARP-1:0]  thread_enable,
  input  logic                         DMemEN,
  input  logic                         MemWrite,
  input  data_t                        imm,
  input  data_t [THREADS_PER_WARP-1:0] rs1,
  input  data_t [THREADS_PER_WARP-1:0] rs2,
  output data_t [THREADS_PER_WARP-1:0] lsu_out,
  output logic                         lsu_done,
  warp_lsu_if.master                   mem
);

  lsu_state_t                   r_state;
  lsu_state_t                   w_next_state;
  data_t [THREADS_PER_WARP-1:0] r_addr_buf;
  data_t [THREADS_PER_WARP-1:0] r_data_buf;
  data_t [THREADS_PER_WARP-1:0] r_lsu_out;
  logic  [THREADS_PER_WARP-1:0] r_mask;
  logic                         r_we;
  logic  [IDX_W-1:0]            r_idx;

  logic                         w_start;
  logic                         w_in_idle;
  logic  [THREADS_PER_WARP-1:0] w_search_mask;
  logic                         w_found;
  logic  [IDX_W-1:0]            w_next_idx;
  logic                         w_rsp_fire;

  assign w_in_idle  = (r_state == IDLE);
  assign w_start    = w_in_idle && warp_enable && (warp_state == WARP_WAIT) && DMemEN;
  assign w_rsp_fire = (r_state == WAIT_RSP) && mem.mem_rsp_valid;

  // In IDLE the mask has not been latched yet, so the first pick looks at the
  // live execution mask; afterwards the search advances over the latched copy.
  assign w_search_mask = w_in_idle ? thread_enable : r_mask;

  lsu_next_thread #(
    .N     (THREADS_PER_WARP),
    .IDX_W (IDX_W)
  ) u_next_thread (
    .i_mask      (w_search_mask),
    .i_idx       (r_idx),
    .i_from_zero (w_in_idle),
    .o_found     (w_found),
    .o_next_idx  (w_next_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // An all-zero mask skips straight to DONE so the warp still sees a
  // completion without any memory traffic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:     if (w_start) w_next_state = w_found ? ISSUE : DONE;
      ISSUE:    if (mem.mem_req_ready) w_next_state = WAIT_RSP;
      WAIT_RSP: if (mem.mem_rsp_valid) w_next_state = w_found ? ISSUE : DONE;
      DONE:     if (warp_state == WARP_UPDATE) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Request fields are driven straight from the latched buffers, so they stay
  // stable under backpressure regardless of what the warp inputs do.
  always_comb begin
    mem.mem_req_valid = 1'b0;
    mem.mem_req_we    = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_wdata = '0;
    lsu_done          = 1'b0;
    unique case (r_state)
      ISSUE: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_we    = r_we;
        mem.mem_req_addr  = r_addr_buf[r_idx];
        mem.mem_req_wdata = r_data_buf[r_idx];
      end
      DONE:    lsu_done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on start, load write-back and lane advance on response.
  // Stores and disabled lanes leave lsu_out untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_buf <= '0;
      r_data_buf <= '0;
      r_lsu_out  <= '0;
      r_mask     <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
    end else begin
      if (w_start) begin
        for (int t = 0; t < THREADS_PER_WARP; t++) begin
          r_addr_buf[t] <= rs1[t] + imm;
          r_data_buf[t] <= rs2[t];
        end
        r_mask <= thread_enable;
        r_we   <= MemWrite;
        r_idx  <= w_next_idx;
      end
      if (w_rsp_fire) begin
        if (!r_we) r_lsu_out[r_idx] <= mem.mem_rsp_data;
        if (w_found) r_idx <= w_next_idx;
      end
    end
  end

  assign lsu_out = r_lsu_out;

endmodule

// File: doc/warp_lsu.md
Name: warp_lsu

Overview:
- Per-warp load/store unit.
- Takes the per-thread rs1/rs2 operands produced by the warp register file and serializes one memory access per enabled thread over a single valid/ready data-memory port.
- Returns per-thread load data on lsu_out for the register-file write-back in WARP_UPDATE.
- Sits between the warp register file and the data-memory arbiter, one instance per warp.

Parameters:
THREADS_PER_WARP, 4, threads per warp; lane count of all per-thread buses.
IDX_W, $clog2(THREADS_PER_WARP) (min 1), width of the thread index counter.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
warp_state  input  warp_state_t  current warp phase (WARP_REQUEST, WARP_WAIT, WARP_UPDATE, ...)
warp_enable  input  1  warp selected this cycle; gates start only
thread_enable  input  THREADS_PER_WARP  execution mask
DMemEN  input  1  instruction is a memory access
MemWrite  input  1  1 = store, 0 = load
imm  input  32  sign-extended offset (data_t)
rs1  input  THREADS_PER_WARP x 32  per-thread base address
rs2  input  THREADS_PER_WARP x 32  per-thread store data
lsu_out  output  THREADS_PER_WARP x 32  per-thread load result
lsu_done  output  1  all enabled accesses complete
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_req_we  output  1  write enable
mem_req_addr  output  32  byte address
mem_req_wdata  output  32  store data
mem_rsp_valid  input  1  response / write-ack valid; no ready (LSU always accepts in WAIT_RSP)
mem_rsp_data  input  32  load data

Behaviour:
- States: IDLE, ISSUE, WAIT_RSP, DONE.
- Reset (async, any state): state=IDLE. mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, lsu_done=0, lsu_out all 0, internal buffers 0. Requests in flight are abandoned.
- Start condition:
  - Requires state=IDLE, warp_enable=1, warp_state=WARP_WAIT, DMemEN=1.
  - Operands are valid from the cycle after WARP_REQUEST.
  - On start, the block latches, per thread: addr_buf[t]=rs1[t]+imm (32-bit wrap, no overflow flag), data_buf[t]=rs2[t], mask_buf=thread_enable, we_buf=MemWrite.
  - Inputs are ignored after capture.
- Start transition:
  - mask_buf nonzero: go to ISSUE, with idx = lowest set bit.
  - mask_buf zero: go directly to DONE next cycle; no memory traffic.
- ISSUE:
  - mem_req_valid=1, addr=addr_buf[idx], wdata=data_buf[idx], we=we_buf.
  - On valid&&ready, go to WAIT_RSP and deassert valid next cycle.
  - valid, addr, wdata and we stay stable until ready, independent of warp_enable and warp_state.
- WAIT_RSP:
  - On mem_rsp_valid, if it is a load, lsu_out[idx]<=mem_rsp_data.
  - Then: next set bit above idx exists -> idx = that bit, go to ISSUE. Otherwise go to DONE.
  - Minimum memory latency is 1 cycle. mem_rsp_valid in ISSUE or IDLE is ignored.
- Throughput: one request outstanding max; 2 cycles minimum per enabled thread, plus 1 cycle to enter DONE.
- DONE:
  - lsu_done=1, held until warp_state=WARP_UPDATE is observed, then IDLE.
  - lsu_done falls in the cycle after the WARP_UPDATE sample.
- lsu_out:
  - Disabled lanes keep their previous value.
  - Stores never modify lsu_out.
  - lsu_out holds until the next load writes that lane.
- warp_enable=0 mid-operation does not stall the FSM; outstanding work completes.
- A start condition while not IDLE is ignored.

Decomposition:
- common_pkg gains lsu_state_t (IDLE, ISSUE, WAIT_RSP, DONE).
- common_pkg already holds data_t and warp_state_t, with WARP_WAIT added to warp_state_t if absent.
- One sub-module: lsu_next_thread, a combinational find-first-set over mask_buf strictly above a given index. It returns found and next_idx, and is used for both the first pick and advancing.

Test Plan:
1. Load, mask=4'b1111, rs1={0x100,0x200,0x300,0x400}, imm=4, 1-cycle memory returning addr^0xFFFF -> requests to 0x104,0x204,0x304,0x404 in order; lsu_out={0xFEFB,0xFDFB,0xFCFB,0xFBFB}; lsu_done high 9 cycles after start.
2. Store, mask=4'b1010, rs1[1]=0x10, rs1[3]=0x30, rs2[1]=0xAA, rs2[3]=0xBB, imm=0 -> exactly two writes (0x10,0xAA) then (0x30,0xBB); lsu_out unchanged.
3. Backpressure: mem_req_ready low 5 cycles on thread 0 with warp_enable toggling -> valid, addr and wdata stable all 5 cycles; exactly one accept.
4. Mask=0, DMemEN=1 -> no mem_req_valid ever; lsu_done next cycle; cleared after WARP_UPDATE.
5. Wrap: rs1=0xFFFFFFFC, imm=8 -> mem_req_addr=0x00000004.
6. Reset asserted in WAIT_RSP of thread 2 -> all outputs 0 immediately; later rsp_valid ignored; a fresh start behaves as scenario 1.
